// File: rtl/rr_arb_4x_nbit.sv
// -----------------------------------------------------------------------------
// rr_arb_4x_nbit
//
// Four-input round-robin arbiter with a registered output stage. Merges four
// valid/ready sources (a..d) onto one output stream and reports which source
// produced the current output word, so a downstream 4:1 mux/demux can follow.
//
// Ports:
//   clk                      rising-edge clock
//   reset_n                  asynchronous, active-low reset
//   a, b, c, d               source data words (BUS_WIDTH bits)
//   a_valid .. d_valid       source holds a word
//   a_ready .. d_ready       source word accepted this cycle (combinational)
//   y                        registered output word
//   y_valid                  y holds a word
//   y_ready                  sink accepts y this cycle
//   sel                      index of the source that produced y (0=a .. 3=d)
// -----------------------------------------------------------------------------
module rr_arb_4x_nbit #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic [BUS_WIDTH-1:0] d,
  input  logic                 a_valid,
  input  logic                 b_valid,
  input  logic                 c_valid,
  input  logic                 d_valid,
  output logic                 a_ready,
  output logic                 b_ready,
  output logic                 c_ready,
  output logic                 d_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [1:0]           sel
);

  logic [3:0]           valid_vec;
  logic [BUS_WIDTH-1:0] data_arr [4];

  assign valid_vec   = {d_valid, c_valid, b_valid, a_valid};
  assign data_arr[0] = a;
  assign data_arr[1] = b;
  assign data_arr[2] = c;
  assign data_arr[3] = d;

  // Output register state and the round-robin pointer.
  logic [BUS_WIDTH-1:0] y_q,       y_d;
  logic                 y_valid_q, y_valid_d;
  logic [1:0]           sel_q,     sel_d;
  logic [1:0]           last_q,    last_d;

  logic       load;
  logic       win_found;
  logic [1:0] win_idx;
  logic [3:0] grant_vec;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = last_q;
    grant_vec = '0;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    sel_d     = sel_q;
    last_d    = last_q;

    // Output register is empty or being drained this cycle.
    load = !y_valid_q || y_ready;

    // Search last+1 .. last+4; the 2-bit sum wraps, so last+4 is last itself.
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && valid_vec[last_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = last_q + 2'(k);
      end
    end

    // reset_n gates the readies so no source sees an accept while in reset.
    if (reset_n && load && win_found) begin
      grant_vec[win_idx] = 1'b1;
    end

    if (load) begin
      if (win_found) begin
        y_d       = data_arr[win_idx];
        sel_d     = win_idx;
        last_d    = win_idx;
        y_valid_d = 1'b1;
      end else begin
        y_valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d input regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;  // a gets first priority after reset
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
    end
  end

  assign a_ready = grant_vec[0];
  assign b_ready = grant_vec[1];
  assign c_ready = grant_vec[2];
  assign d_ready = grant_vec[3];
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign sel     = sel_q;

endmodule
